// File: rtl/univ_reg_pkg.sv
// Shared definitions for the universal register: operating-mode encoding.
// Imported by the interface, the register top and the testbench.
package univ_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_e;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

endpackage : univ_reg_pkg

// File: rtl/univ_reg_if.sv
// Control/data bundle of the universal register.
// The master drives the operation; the slave (the register) returns its state.
interface univ_reg_if #(
    parameter int WIDTH = 8
);
    import univ_reg_pkg::*;

    logic             en;
    mode_e            mode;
    logic [WIDTH-1:0] d;
    logic             ser_lsb;
    logic             ser_msb;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             cout;
    logic             zero;

    modport master (
        output en, mode, d, ser_lsb, ser_msb,
        input  q, qbar, cout, zero
    );

    modport slave (
        input  en, mode, d, ser_lsb, ser_msb,
        output q, qbar, cout, zero
    );

endinterface : univ_reg_if

// File: rtl/univ_reg_dff_cell.sv
// Single-bit D storage cell: synchronous active-high reset to a per-instance
// value, clock enable, true and complement outputs.
module dff_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q,
    output logic qbar
);

    // NOTE: sequential state is written with <= so every cell samples the
    // pre-edge value of its neighbours; blocking here would make shifts ripple.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

    assign qbar = ~q;

endmodule : dff_cell

// File: rtl/univ_reg.sv
// WIDTH-bit universal register built from dff_cell bits: hold, load,
// shift, rotate, increment and decrement, with a registered carry/shift-out.
module univ_reg
    import univ_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic        clk,
    input  logic        rst,
    univ_reg_if.slave   bus
);

    logic [WIDTH-1:0] q_cur;
    logic [WIDTH-1:0] qbar_cur;
    logic [WIDTH-1:0] q_next;
    logic             cout_cur;
    logic             cout_n;
    logic             cout_next;
    logic [WIDTH:0]   inc_sum;

    assign inc_sum = {1'b0, q_cur} + {{WIDTH{1'b0}}, 1'b1};

    // NOTE: both outputs get a default before the case, so no path through
    // this block can leave them unassigned and infer a latch.
    always_comb begin
        q_next    = q_cur;
        cout_next = 1'b0;
        case (bus.mode)
            MODE_HOLD: begin
                q_next    = q_cur;
                cout_next = 1'b0;
            end
            MODE_LOAD: begin
                q_next    = bus.d;
                cout_next = 1'b0;
            end
            MODE_SHL: begin
                q_next    = {q_cur[WIDTH-2:0], bus.ser_lsb};
                cout_next = q_cur[WIDTH-1];
            end
            MODE_SHR: begin
                q_next    = {bus.ser_msb, q_cur[WIDTH-1:1]};
                cout_next = q_cur[0];
            end
            MODE_ROL: begin
                q_next    = {q_cur[WIDTH-2:0], q_cur[WIDTH-1]};
                cout_next = q_cur[WIDTH-1];
            end
            MODE_ROR: begin
                q_next    = {q_cur[0], q_cur[WIDTH-1:1]};
                cout_next = q_cur[0];
            end
            MODE_INC: begin
                q_next    = inc_sum[WIDTH-1:0];
                cout_next = inc_sum[WIDTH];
            end
            MODE_DEC: begin
                q_next    = q_cur - {{(WIDTH-1){1'b0}}, 1'b1};
                cout_next = (q_cur == '0);
            end
            default: begin
                q_next    = 'x;
                cout_next = 1'bx;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_cell #(
            .RST_VAL (RESET_VAL[i])
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .en   (bus.en),
            .d    (q_next[i]),
            .q    (q_cur[i]),
            .qbar (qbar_cur[i])
        );
    end

    dff_cell #(
        .RST_VAL (1'b0)
    ) u_cout (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .d    (cout_next),
        .q    (cout_cur),
        .qbar (cout_n)
    );

    assign bus.q    = q_cur;
    assign bus.qbar = qbar_cur;
    assign bus.cout = cout_cur;
    assign bus.zero = ~|q_cur;

    initial_width_ok : assert final (WIDTH >= MIN_WIDTH && WIDTH <= MAX_WIDTH);

    // An unknown mode while enabled is an illegal use of the register.
    mode_known : assert property (@(posedge clk) (!rst && bus.en) |-> !$isunknown(bus.mode));

    cout_rails : assert property (@(posedge clk)
        (!rst && !$isunknown(cout_cur)) |-> (cout_n == ~cout_cur));

endmodule : univ_reg

// File: tb/tb_univ_reg.sv
// Directed self-checking bench for univ_reg at WIDTH 8 (RESET_VAL A5), 2 and 32.
module tb_univ_reg;
    import univ_reg_pkg::*;

    logic clk = 1'b0;
    logic rst8, rst2, rst32;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    univ_reg_if #(.WIDTH(8))  bus8 ();
    univ_reg_if #(.WIDTH(2))  bus2 ();
    univ_reg_if #(.WIDTH(32)) bus32 ();

    univ_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
        .clk (clk), .rst (rst8), .bus (bus8.slave)
    );
    univ_reg #(.WIDTH(2), .RESET_VAL(2'b00)) u_dut2 (
        .clk (clk), .rst (rst2), .bus (bus2.slave)
    );
    univ_reg #(.WIDTH(32), .RESET_VAL(32'h0)) u_dut32 (
        .clk (clk), .rst (rst32), .bus (bus32.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic step8(input logic r, input logic e, input mode_e m,
                         input logic [7:0] dd, input logic sl, input logic sm);
        rst8 = r; bus8.en = e; bus8.mode = m; bus8.d = dd;
        bus8.ser_lsb = sl; bus8.ser_msb = sm;
        @(posedge clk); #1;
        bus8.en = 1'b0; rst8 = 1'b0;
    endtask

    task automatic step2(input logic r, input mode_e m, input logic [1:0] dd,
                         input logic sl, input logic sm);
        rst2 = r; bus2.en = 1'b1; bus2.mode = m; bus2.d = dd;
        bus2.ser_lsb = sl; bus2.ser_msb = sm;
        @(posedge clk); #1;
        bus2.en = 1'b0; rst2 = 1'b0;
    endtask

    task automatic step32(input logic r, input mode_e m, input logic [31:0] dd,
                          input logic sl, input logic sm);
        rst32 = r; bus32.en = 1'b1; bus32.mode = m; bus32.d = dd;
        bus32.ser_lsb = sl; bus32.ser_msb = sm;
        @(posedge clk); #1;
        bus32.en = 1'b0; rst32 = 1'b0;
    endtask

    task automatic chk8(input string tag, input logic [7:0] eq, input logic ec);
        check({tag, ".q"},    {56'h0, bus8.q},    {56'h0, eq});
        check({tag, ".qbar"}, {56'h0, bus8.qbar}, {56'h0, ~eq});
        check({tag, ".cout"}, {63'h0, bus8.cout}, {63'h0, ec});
        check({tag, ".zero"}, {63'h0, bus8.zero}, {63'h0, (eq == 8'h00)});
    endtask

    task automatic chk2(input string tag, input logic [1:0] eq, input logic ec);
        check({tag, ".q"},    {62'h0, bus2.q},    {62'h0, eq});
        check({tag, ".cout"}, {63'h0, bus2.cout}, {63'h0, ec});
        check({tag, ".zero"}, {63'h0, bus2.zero}, {63'h0, (eq == 2'b00)});
    endtask

    task automatic chk32(input string tag, input logic [31:0] eq, input logic ec);
        check({tag, ".q"},    {32'h0, bus32.q},    {32'h0, eq});
        check({tag, ".cout"}, {63'h0, bus32.cout}, {63'h0, ec});
        check({tag, ".zero"}, {63'h0, bus32.zero}, {63'h0, (eq == 32'h0)});
    endtask

    // ROL x8 from 8'h96: expected q and cout after each edge.
    logic [7:0] rol_q [8] = '{8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B, 8'h96};
    logic       rol_c [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst8 = 1'b1; rst2 = 1'b1; rst32 = 1'b1;
        bus8.en  = 1'b0; bus8.mode  = MODE_HOLD; bus8.d  = '0; bus8.ser_lsb  = 1'b0; bus8.ser_msb  = 1'b0;
        bus2.en  = 1'b0; bus2.mode  = MODE_HOLD; bus2.d  = '0; bus2.ser_lsb  = 1'b0; bus2.ser_msb  = 1'b0;
        bus32.en = 1'b0; bus32.mode = MODE_HOLD; bus32.d = '0; bus32.ser_lsb = 1'b0; bus32.ser_msb = 1'b0;
        @(posedge clk); #1;
        rst2 = 1'b0; rst32 = 1'b0;

        // Reset and load
        step8(1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        chk8("reset", 8'hA5, 1'b0);
        step8(1'b0, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0);
        chk8("load_3c", 8'h3C, 1'b0);

        // Shift with serial fill
        step8(1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
        chk8("load_81", 8'h81, 1'b0);
        step8(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        chk8("shl", 8'h03, 1'b1);
        step8(1'b0, 1'b1, MODE_SHR, 8'h00, 1'b1, 1'b0);
        chk8("shr", 8'h01, 1'b1);

        // Rotate round-trip
        step8(1'b0, 1'b1, MODE_LOAD, 8'h96, 1'b0, 1'b0);
        chk8("load_96", 8'h96, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step8(1'b0, 1'b1, MODE_ROL, 8'hFF, 1'b0, 1'b0);
            chk8($sformatf("rol%0d", i), rol_q[i], rol_c[i]);
        end
        step8(1'b0, 1'b1, MODE_ROR, 8'h00, 1'b1, 1'b1);
        chk8("ror_96", 8'h4B, 1'b0);
        step8(1'b0, 1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0);
        chk8("ror_4b", 8'hA5, 1'b1);
        step8(1'b0, 1'b1, MODE_HOLD, 8'hFF, 1'b1, 1'b1);
        chk8("hold_clr", 8'hA5, 1'b0);

        // Counter wrap both ways
        step8(1'b0, 1'b1, MODE_LOAD, 8'hFE, 1'b0, 1'b0);
        step8(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0, 1'b0);
        chk8("inc_fe", 8'hFF, 1'b0);
        step8(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0, 1'b0);
        chk8("inc_ff", 8'h00, 1'b1);
        step8(1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0, 1'b0);
        chk8("dec_00", 8'hFF, 1'b1);
        step8(1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0, 1'b0);
        chk8("dec_ff", 8'hFE, 1'b0);

        // Enable freeze keeps q and a set cout; reset beats enable
        step8(1'b0, 1'b1, MODE_LOAD, 8'h88, 1'b0, 1'b0);
        step8(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
        chk8("shl_88", 8'h10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step8(1'b0, 1'b0, MODE_INC, 8'h55, 1'b1, 1'b1);
            chk8($sformatf("en0_%0d", i), 8'h10, 1'b1);
        end
        step8(1'b1, 1'b1, MODE_INC, 8'h00, 1'b0, 1'b0);
        chk8("rst_inc", 8'hA5, 1'b0);
        step8(1'b0, 1'b1, MODE_LOAD, 8'h00, 1'b0, 1'b0);
        chk8("load_00", 8'h00, 1'b0);

        // WIDTH=2
        chk2("w2_reset", 2'b00, 1'b0);
        step2(1'b0, MODE_LOAD, 2'b11, 1'b0, 1'b0);
        step2(1'b0, MODE_INC, 2'b00, 1'b0, 1'b0);
        chk2("w2_inc_wrap", 2'b00, 1'b1);
        step2(1'b0, MODE_LOAD, 2'b10, 1'b0, 1'b0);
        step2(1'b0, MODE_SHL, 2'b00, 1'b1, 1'b0);
        chk2("w2_shl", 2'b01, 1'b1);
        step2(1'b0, MODE_SHR, 2'b00, 1'b0, 1'b1);
        chk2("w2_shr", 2'b10, 1'b1);
        step2(1'b0, MODE_ROR, 2'b00, 1'b1, 1'b1);
        chk2("w2_ror", 2'b01, 1'b0);
        step2(1'b0, MODE_DEC, 2'b00, 1'b0, 1'b0);
        chk2("w2_dec", 2'b00, 1'b0);

        // WIDTH=32
        chk32("w32_reset", 32'h0, 1'b0);
        step32(1'b0, MODE_LOAD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step32(1'b0, MODE_INC, 32'h0, 1'b0, 1'b0);
        chk32("w32_inc_wrap", 32'h0, 1'b1);
        step32(1'b0, MODE_LOAD, 32'h8000_0001, 1'b0, 1'b0);
        step32(1'b0, MODE_SHL, 32'h0, 1'b0, 1'b1);
        chk32("w32_shl", 32'h0000_0002, 1'b1);
        step32(1'b0, MODE_SHR, 32'h0, 1'b0, 1'b1);
        chk32("w32_shr", 32'h8000_0001, 1'b0);
        step32(1'b0, MODE_ROL, 32'h0, 1'b0, 1'b0);
        chk32("w32_rol", 32'h0000_0003, 1'b1);
        step32(1'b0, MODE_LOAD, 32'h0, 1'b0, 1'b0);
        step32(1'b0, MODE_DEC, 32'h0, 1'b0, 1'b0);
        chk32("w32_dec_wrap", 32'hFFFF_FFFF, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_univ_reg

// File: doc/univ_reg.md
Name: univ_reg

Overview:
- Parametrised successor to the team's single-bit D storage element.
- A WIDTH-bit edge-triggered register with synchronous reset, clock enable and eight operating modes:
  - hold and parallel load;
  - logical shift left and right;
  - rotate left and right;
  - increment and decrement.
- Provides true and complement outputs like the single-bit cell, plus a registered carry/shift-out flag.
- Used as the general storage/shift/count primitive for datapath registers and the future processor's PC/accumulator.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  clock enable; 0 = freeze all state.
- mode  input  3  operation select (encoding below).
- d  input  WIDTH  parallel load data.
- ser_lsb  input  1  serial bit shifted into bit 0 on SHL.
- ser_msb  input  1  serial bit shifted into bit WIDTH-1 on SHR.
- q  output  WIDTH  register contents.
- qbar  output  WIDTH  bitwise complement of q.
- cout  output  1  registered carry/borrow/shifted-out bit from the last enabled operation.
- zero  output  1  high when q == 0.

Behaviour:
- Reset and clocking:
  - One clock (clk); reset rst is synchronous and active-high, sampled on the rising edge of clk only.
  - Priority per rising edge: rst > en > mode.
  - rst=1: q <= RESET_VAL, cout <= 0, regardless of en/mode.
  - Reset asserted mid-sequence (e.g. during a count run) discards the operation in that cycle; no partial update.
- Enable: en=0 and rst=0 means q and cout hold their values; mode, d and serial inputs are ignored.
- Latency: one cycle; the result of an operation sampled at edge N is visible on q/cout just after edge N.
- Combinational outputs, no register stage:
  - qbar = ~q at all times.
  - zero = ~|q.
- Mode encoding and action (en=1, rst=0; q' is the next value):
  - 3'b000 HOLD: q' = q; cout' = 0.
  - 3'b001 LOAD: q' = d; cout' = 0.
  - 3'b010 SHL: q' = {q[WIDTH-2:0], ser_lsb}; cout' = q[WIDTH-1].
  - 3'b011 SHR: q' = {ser_msb, q[WIDTH-1:1]}; cout' = q[0].
  - 3'b100 ROL: q' = {q[WIDTH-2:0], q[WIDTH-1]}; cout' = q[WIDTH-1].
  - 3'b101 ROR: q' = {q[0], q[WIDTH-1:1]}; cout' = q[0].
  - 3'b110 INC: q' = q + 1 modulo 2^WIDTH; cout' = 1 iff q was all ones (wrap to 0).
  - 3'b111 DEC: q' = q - 1 modulo 2^WIDTH; cout' = 1 iff q was 0 (wrap to all ones).
- Arithmetic: unsigned, WIDTH-bit, no saturation; wrap-around is normal behaviour, signalled only via cout for that one cycle.
- cout semantics:
  - Reflects only the most recent enabled, non-reset edge.
  - Cleared by HOLD/LOAD with en=1.
  - Retained while en=0.
- X-handling: an unknown mode with en=1 is not a legal use; it is flagged by a simulation assertion, and synthesis treats it as don't-care.
- No combinational path from any input to q/cout; the only comb outputs are qbar and zero, derived from q.

Decomposition:
- Shared package univ_reg_pkg holds:
  - mode constants MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_INC, MODE_DEC (3-bit);
  - the mode typedef.
- One natural sub-module: dff_cell (1-bit, synchronous active-high rst with per-instance reset value, en, d, q, qbar).
- Structure:
  - univ_reg instantiates WIDTH dff_cell plus one for cout.
  - The next-state mux (shift/rotate/add/sub) is combinational logic in univ_reg.

Test Plan:
- Reset and load, WIDTH=8, RESET_VAL=8'hA5: rst=1 for 1 edge -> q=8'hA5, qbar=8'h5A, cout=0, zero=0. Then LOAD d=8'h3C -> q=8'h3C after one edge, cout=0.
- Shift with serial fill: q=8'h81, SHL ser_lsb=1 -> q=8'h03, cout=1. Then SHR ser_msb=0 -> q=8'h01, cout=1.
- Rotate round-trip: q=8'h96, ROL x8 -> q returns to 8'h96. cout sequence equals MSB-first bits of 8'h96 (1,0,0,1,0,1,1,0).
- Counter wrap in both directions:
  - q=8'hFE, INC x2 -> q=8'hFF (cout=0), then 8'h00 (cout=1, zero=1).
  - DEC x1 -> q=8'hFF, cout=1.
- Enable and reset priority:
  - q=8'h10, INC with en=0 for 3 edges -> q=8'h10, cout unchanged.
  - INC with en=1 and rst=1 on the same edge -> q=RESET_VAL, cout=0.
- Parameter sweep: WIDTH=2 and WIDTH=32 (RESET_VAL=0) -> INC from all-ones wraps to 0 with cout=1; SHL/SHR boundary bits correct.
